fpu_addsub_issue_stage: RTL
===========================

Name: fpu_addsub_issue_stage

Overview:
Registered issue/retire wrapper placed directly upstream and downstream of the combinational IEEE-754 single-precision add/sub unit in the CPU FPU.
- Accepts operand pairs through a valid/ready handshake and holds them stable in an issue register that drives the unit.
- Captures the unit's result and exception into a retire register with its own valid/ready handshake.
- Keeps a sticky exception flag and a completed-operation counter for the CPU status path.

Parameters:
TAG_W, 4, width of the caller-supplied tag carried alongside each operation
CNT_W, 16, width of the completed-operation counter

Ports:
CLK  input  1  system clock; all state updates on its rising edge
RESET  input  1  synchronous, active-high reset
in_valid  input  1  operand pair offered
in_ready  output  1  stage can accept an operand pair this cycle
in_a  input  32  operand A (IEEE-754)
in_b  input  32  operand B (IEEE-754)
in_sub  input  1  0 = A+B, 1 = A-B
in_tag  input  TAG_W  caller tag
fu_a  output  32  operand A to the add/sub unit (issue register)
fu_b  output  32  operand B to the add/sub unit
fu_sub  output  1  operation select to the add/sub unit
fu_result  input  32  unit result (combinational from fu_*)
fu_exception  input  1  unit exception flag (either exponent = 255)
out_valid  output  1  retired result available
out_ready  input  1  consumer accepts the result
out_result  output  32  retired result
out_exception  output  1  retired exception flag
out_tag  output  TAG_W  tag of the retired result
clr_status  input  1  clear the sticky exception flag
sticky_exc  output  1  set when any retired op raised an exception
op_count  output  CNT_W  number of out handshakes completed; wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock domain, CLK. RESET is synchronous and active-high.
- Reset values: s1_valid=0, out_valid=0, out_result=0, out_exception=0, out_tag=0, sticky_exc=0, op_count=0, fu_a=0, fu_b=0, fu_sub=0. in_ready=0 while RESET=1.
- Issue register (S1): s1_valid, fu_a, fu_b, fu_sub, s1_tag.
- Retire register (S2): out_valid, out_result, out_exception, out_tag.
- Advance condition: s1_adv = s1_valid & (~out_valid | out_ready).
- Ready: in_ready = ~RESET & (~s1_valid | s1_adv). This is combinational from out_ready and state; there is no combinational in_valid->in_ready path.
- Accept: in_valid & in_ready at edge k loads S1. fu_* then show the new operands after edge k. The unit settles within the same cycle.
- Retire: on s1_adv, S2 captures fu_result, fu_exception and s1_tag, and sets out_valid. S1 is cleared unless a new accept occurs at the same edge; if one does, S1 reloads.
- Latency: accept at edge k -> out_valid=1 after edge k+1. Throughput is 1 op/cycle when out_ready is held at 1.
- Output drain: if out_valid & out_ready and no s1_adv, out_valid=0 next cycle.
- Backpressure: while out_valid & ~out_ready, S2 holds and S1 holds. With S1 full, in_ready=0. At most 2 ops in flight. All out_* and fu_* must be stable while stalled.
- Exception retire: out_result is passed through exactly as the unit produced it (0 on exception). No local rounding or special-case logic.
- sticky_exc:
  - Set at an S2 capture with fu_exception=1.
  - Cleared by clr_status.
  - If clr_status and a set occur at the same edge, set wins.
- op_count: increments on each out_valid & out_ready edge and wraps from all-ones to 0.
- Reset mid-operation: all in-flight ops are discarded with no out_valid pulse. Counter and sticky flag are cleared.

Decomposition:
- Shared package fpu_pkg holds:
  - FP_W=32, EXP_MSB=30, EXP_LSB=23, MAN_MSB=22.
  - Op encoding localparams OP_ADD=1'b0, OP_SUB=1'b1.
  - A helper constant FP_ZERO=32'h0.
- One natural sub-module, fpu_pipe_slot: a parameterised data+valid register with load/clear/hold. It is instantiated for S1 and S2. Handshake logic, counter and sticky flag live in the top module.

Test Plan:
- Single add: 0x3F800000 + 0x40000000, tag 3, out_ready=1 -> out_valid after edge k+1, out_result=0x40400000, out_exception=0, out_tag=3, op_count=1.
- Single sub: 0x40400000 - 0x3F800000 -> out_result=0x40000000. Then 0x3F800000 - 0x40400000 -> 0xC0000000.
- Back-to-back: 8 ops with in_valid=1, out_ready=1 -> in_ready stays 1, 8 consecutive out_valid cycles in order, tags 0..7, op_count=8.
- Backpressure: out_ready=0 for 5 cycles while 3 ops are offered -> 2 accepted, then in_ready=0, outputs stable. Releasing out_ready -> 3 results in order, none lost or duplicated.
- Exception: 0x7F800000 + 0x3F800000 -> out_exception=1, out_result=0, sticky_exc=1. clr_status coincident with another exception retire -> sticky_exc stays 1. clr_status alone -> 0.
- Reset mid-flight: 2 ops in flight, RESET=1 for one cycle -> no out_valid afterwards, op_count=0, in_ready=0 during reset and 1 in the first cycle after.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared single-precision FPU constants used by the add/sub issue stage and its neighbours.
package fpu_pkg;

   localparam int unsigned FP_W    = 32;
   localparam int unsigned EXP_MSB = 30;
   localparam int unsigned EXP_LSB = 23;
   localparam int unsigned MAN_MSB = 22;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam logic [FP_W-1:0] FP_ZERO = 32'h0;

endpackage

// File: rtl/fpu_pipe_slot.sv
// One pipeline slot: a data word plus valid bit that can be loaded, cleared or held.
module fpu_pipe_slot #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   // Load beats clear so a retiring slot can refill in the same cycle.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (clear_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/fpu_addsub_issue_stage.sv
// Issue/retire registers around the combinational add/sub unit, with sticky
// exception flag and completed-operation counter for the status path.
module fpu_addsub_issue_stage
   import fpu_pkg::*;
#(
   parameter int unsigned TAG_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [FP_W-1:0]  in_a,
   input  logic [FP_W-1:0]  in_b,
   input  logic             in_sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic [FP_W-1:0]  fu_a,
   output logic [FP_W-1:0]  fu_b,
   output logic             fu_sub,
   input  logic [FP_W-1:0]  fu_result,
   input  logic             fu_exception,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [FP_W-1:0]  out_result,
   output logic             out_exception,
   output logic [TAG_W-1:0] out_tag,
   input  logic             clr_status,
   output logic             sticky_exc,
   output logic [CNT_W-1:0] op_count
);

   localparam int unsigned S1_W = 2 * FP_W + 1 + TAG_W;
   localparam int unsigned S2_W = FP_W + 1 + TAG_W;

   logic             s1_valid;
   logic [S1_W-1:0]  s1_data;
   logic [TAG_W-1:0] s1_tag;
   logic [S2_W-1:0]  s2_data;
   logic             s1_adv;
   logic             accept;
   logic             out_fire;

   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] count_q, count_d;

   // S1 moves on whenever S2 is empty or draining this cycle.
   assign s1_adv   = s1_valid & (~out_valid | out_ready);
   assign in_ready = ~RESET & (~s1_valid | s1_adv);
   assign accept   = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   fpu_pipe_slot #(.W(S1_W)) u_s1 (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .load_i  (accept),
      .clear_i (s1_adv),
      .data_i  ({in_a, in_b, in_sub, in_tag}),
      .valid_o (s1_valid),
      .data_o  (s1_data)
   );

   assign fu_a   = s1_data[S1_W-1 -: FP_W];
   assign fu_b   = s1_data[TAG_W+1 +: FP_W];
   assign fu_sub = s1_data[TAG_W];
   assign s1_tag = s1_data[TAG_W-1:0];

   fpu_pipe_slot #(.W(S2_W)) u_s2 (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .load_i  (s1_adv),
      .clear_i (out_fire),
      .data_i  ({fu_result, fu_exception, s1_tag}),
      .valid_o (out_valid),
      .data_o  (s2_data)
   );

   assign out_result    = s2_data[S2_W-1 -: FP_W];
   assign out_exception = s2_data[TAG_W];
   assign out_tag       = s2_data[TAG_W-1:0];

   // A new exception capture outranks a coincident clear.
   always_comb begin
      sticky_d = sticky_q;
      count_d  = count_q;
      if (s1_adv && fu_exception) begin
         sticky_d = 1'b1;
      end else if (clr_status) begin
         sticky_d = 1'b0;
      end
      if (out_fire) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sticky_q <= 1'b0;
         count_q  <= '0;
      end else begin
         sticky_q <= sticky_d;
         count_q  <= count_d;
      end
   end

   assign sticky_exc = sticky_q;
   assign op_count   = count_q;

endmodule
